// File: rtl/ic_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller and the IF stage.
package ic_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_WAIT = 2'd2,
        IC_FILL = 2'd3
    } ic_state_e;

    localparam int          IC_LINE_OFS_W = 4;
    localparam logic [31:0] IC_NOP        = 32'h0000_0013;

endpackage

// File: rtl/ic_tag_array.sv
// Direct-mapped tag/valid store: combinational read, single write port, flash-clear of valids.
module ic_tag_array #(
    parameter int IDX_W = 12,
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    // NOTE: these are flop arrays, not RAM macros, so they can and must take the reset;
    // valid bits in particular have to start known or the first lookups are garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            if (clr)        valid_q         <= '0;
            else if (wr_en) valid_q[wr_idx] <= 1'b1;
            if (wr_en)      tag_q[wr_idx]   <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/ic_refill_ctrl.sv
// I-cache miss/refill sequencer and IF-stage stall generator.
// Optional hit/miss counters with perf_clr when IC_PERF_CNT_EN is defined.
module ic_refill_ctrl
    import ic_refill_ctrl_pkg::*;
#(
    parameter int IWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [29:0]       pc_if,
    input  logic              fetch_en,
    input  logic              fence_i,
    output logic              ic_req,
    output logic [27:0]       ic_req_adr,
    input  logic              ic_req_ack,
    input  logic              ic_rdat_m_valid,
    output logic [IWIDTH-3:0] ic_ram_wadr_all,
    output logic              ic_stall,
    output logic              ic_stall_dly,
    output logic              ic_stall_fin,
`ifdef IC_PERF_CNT_EN
    output logic              ic_stall_fin2,
    input  logic              perf_clr,
    output logic [31:0]       ic_hit_cnt,
    output logic [31:0]       ic_miss_cnt
`else
    output logic              ic_stall_fin2
`endif
);
    localparam int IDX_W = IWIDTH - 2;
    localparam int TAG_W = 30 - IWIDTH;

    ic_state_e        state_q, state_d;
    logic [27:0]      madr_q;
    logic             fence_pend_q, fence_pend_d;
    logic [IDX_W-1:0] wadr_q;
    logic             stall_dly_q, fin2_q;

    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic             lookup, hit, miss;
    logic             tag_wr, tag_clr;

    assign pc_idx = pc_if[IWIDTH-1:2];
    assign pc_tag = pc_if[29:IWIDTH];

    // Word offset within the line does not take part in the lookup.
    logic unused_word_ofs;
    assign unused_word_ofs = ^pc_if[1:0];

    ic_tag_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pc_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .wr_en    (tag_wr),
        .wr_idx   (madr_q[IDX_W-1:0]),
        .wr_tag   (madr_q[27:IDX_W]),
        .clr      (tag_clr)
    );

    // A fence cycle in IDLE suppresses the lookup so the flash-clear wins.
    assign lookup = fetch_en && !fence_i && (state_q == IC_IDLE);
    assign hit    = rd_valid && (rd_tag == pc_tag);
    assign miss   = lookup && !hit;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        fence_pend_d = fence_pend_q;
        tag_wr       = 1'b0;
        tag_clr      = 1'b0;
        unique case (state_q)
            IC_IDLE: begin
                if (fence_i)   tag_clr = 1'b1;
                else if (miss) state_d = IC_REQ;
            end
            IC_REQ: begin
                if (fence_i)    fence_pend_d = 1'b1;
                if (ic_req_ack) state_d      = IC_WAIT;
            end
            IC_WAIT: begin
                if (fence_i) fence_pend_d = 1'b1;
                if (ic_rdat_m_valid) begin
                    tag_wr  = 1'b1;
                    state_d = IC_FILL;
                end
            end
            IC_FILL: begin
                // Deferred fence also drops the line installed by this refill.
                tag_clr      = fence_pend_q || fence_i;
                fence_pend_d = 1'b0;
                state_d      = IC_IDLE;
            end
            default: state_d = IC_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IC_IDLE;
            madr_q       <= '0;
            fence_pend_q <= 1'b0;
            wadr_q       <= '0;
            stall_dly_q  <= 1'b0;
            fin2_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fence_pend_q <= fence_pend_d;
            stall_dly_q  <= ic_stall;
            fin2_q       <= ic_stall_fin;
            if (miss) begin
                madr_q <= pc_if[29:2];
                wadr_q <= pc_idx;
            end else if (state_q == IC_FILL) begin
                wadr_q <= '0;
            end
        end
    end

    assign ic_stall        = (state_q != IC_IDLE);
    assign ic_stall_dly    = stall_dly_q;
    assign ic_stall_fin    = !ic_stall && stall_dly_q;
    assign ic_stall_fin2   = fin2_q;
    assign ic_req          = (state_q == IC_REQ);
    assign ic_req_adr      = ic_req ? madr_q : '0;
    assign ic_ram_wadr_all = wadr_q;

`ifdef IC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_hit_cnt  <= '0;
            ic_miss_cnt <= '0;
        end else if (perf_clr) begin
            ic_hit_cnt  <= '0;
            ic_miss_cnt <= '0;
        end else begin
            if (lookup && hit) ic_hit_cnt  <= ic_hit_cnt + 32'd1;
            if (miss)          ic_miss_cnt <= ic_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Scoreboard bench for ic_refill_ctrl: a reference tag/valid model predicts hit or miss per fetch.
module tb_ic_refill_ctrl;
    localparam int IWIDTH = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [29:0]       pc_if;
    logic              fetch_en, fence_i;
    logic              ic_req;
    logic [27:0]       ic_req_adr;
    logic              ic_req_ack, ic_rdat_m_valid;
    logic [IWIDTH-3:0] ic_ram_wadr_all;
    logic              ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2;
`ifdef IC_PERF_CNT_EN
    logic              perf_clr;
    logic [31:0]       ic_hit_cnt, ic_miss_cnt;
`endif

    ic_refill_ctrl #(.IWIDTH(IWIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_if           (pc_if),
        .fetch_en        (fetch_en),
        .fence_i         (fence_i),
        .ic_req          (ic_req),
        .ic_req_adr      (ic_req_adr),
        .ic_req_ack      (ic_req_ack),
        .ic_rdat_m_valid (ic_rdat_m_valid),
        .ic_ram_wadr_all (ic_ram_wadr_all),
        .ic_stall        (ic_stall),
        .ic_stall_dly    (ic_stall_dly),
        .ic_stall_fin    (ic_stall_fin),
`ifdef IC_PERF_CNT_EN
        .ic_stall_fin2   (ic_stall_fin2),
        .perf_clr        (perf_clr),
        .ic_hit_cnt      (ic_hit_cnt),
        .ic_miss_cnt     (ic_miss_cnt)
`else
        .ic_stall_fin2   (ic_stall_fin2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        miss;
        logic [27:0] adr;
    } exp_t;

    exp_t        sb[$];
    bit [4095:0] m_valid;
    bit [15:0]   m_tag [4096];
    int          vectors = 0;
    int          miscompares = 0;

    // One fetch of one lookup cycle; on a predicted miss, walks the refill handshake.
    task automatic do_fetch(input logic [31:0] pc, input int ack_dly, input int dat_dly,
                            input bit spur, input bit fence_busy);
        exp_t        e;
        logic [11:0] idx;
        logic [15:0] tg;
        idx = pc[15:4];
        tg  = pc[31:16];
        @(negedge clk);
        pc_if    = pc[31:2];
        fetch_en = 1'b1;
        e.miss   = !(m_valid[idx] && m_tag[idx] == tg);
        e.adr    = pc[31:4];
        sb.push_back(e);
        @(negedge clk);
        fetch_en = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({ic_req, ic_stall} !== {e.miss, e.miss}) begin
            miscompares++;
            $display("FAIL lookup pc=%h: req/stall got %b expected %b", pc, {ic_req, ic_stall}, {e.miss, e.miss});
        end
        if (!e.miss) return;
        vectors++;
        if (ic_req_adr !== e.adr) begin
            miscompares++;
            $display("FAIL req_adr pc=%h: got %h expected %h", pc, ic_req_adr, e.adr);
        end
        for (int i = 0; i < ack_dly; i++) begin
            ic_rdat_m_valid = spur && (i == 0);
            @(negedge clk);
            ic_rdat_m_valid = 1'b0;
            vectors++;
            if ({ic_req, ic_req_adr, ic_stall} !== {1'b1, e.adr, 1'b1}) begin
                miscompares++;
                $display("FAIL req_hold pc=%h cyc=%0d: req=%b adr=%h stall=%b expected 1/%h/1", pc, i, ic_req, ic_req_adr, ic_stall, e.adr);
            end
        end
        ic_req_ack = 1'b1;
        @(negedge clk);
        ic_req_ack = 1'b0;
        for (int i = 0; i <= dat_dly; i++) begin
            vectors++;
            if ({ic_req, ic_stall, ic_ram_wadr_all} !== {1'b0, 1'b1, idx}) begin
                miscompares++;
                $display("FAIL wait pc=%h cyc=%0d: req=%b stall=%b wadr=%h expected 0/1/%h", pc, i, ic_req, ic_stall, ic_ram_wadr_all, idx);
            end
            fence_i         = fence_busy && (i == 0);
            ic_rdat_m_valid = (i == dat_dly);
            @(negedge clk);
            fence_i         = 1'b0;
            ic_rdat_m_valid = 1'b0;
        end
        m_tag[idx]   = tg;
        m_valid[idx] = 1'b1;
        if (fence_busy) m_valid = '0;
        vectors++;
        if ({ic_req, ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2, ic_ram_wadr_all} !== {5'b01100, idx}) begin
            miscompares++;
            $display("FAIL fill pc=%h: req/stall/dly/fin/fin2=%b wadr=%h expected 01100/%h", pc,
                     {ic_req, ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2}, ic_ram_wadr_all, idx);
        end
        @(negedge clk);
        vectors++;
        if ({ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2, ic_ram_wadr_all} !== {4'b0110, 12'h000}) begin
            miscompares++;
            $display("FAIL resume1 pc=%h: stall/dly/fin/fin2=%b wadr=%h expected 0110/000", pc,
                     {ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2}, ic_ram_wadr_all);
        end
        @(negedge clk);
        vectors++;
        if ({ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2} !== 4'b0001) begin
            miscompares++;
            $display("FAIL resume2 pc=%h: stall/dly/fin/fin2=%b expected 0001", pc, {ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2});
        end
        @(negedge clk);
        vectors++;
        if ({ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2} !== 4'b0000) begin
            miscompares++;
            $display("FAIL resume3 pc=%h: stall/dly/fin/fin2=%b expected 0000", pc, {ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_if = '0; fetch_en = 1'b0; fence_i = 1'b0;
        ic_req_ack = 1'b0; ic_rdat_m_valid = 1'b0;
`ifdef IC_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        m_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ic_req, ic_req_adr, ic_ram_wadr_all, ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2} !== '0) begin
            miscompares++;
            $display("FAIL reset: req=%b adr=%h wadr=%h stall family=%b expected all 0", ic_req, ic_req_adr,
                     ic_ram_wadr_all, {ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2});
        end
    endtask

    task automatic test_cold_start();
        do_fetch(32'h0000_0100, 2, 5, 1'b0, 1'b0);
    endtask

    task automatic test_hit_after_fill();
        do_fetch(32'h0000_0100, 1, 0, 1'b0, 1'b0);
        do_fetch(32'h0000_010C, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_conflict();
        do_fetch(32'h0001_0100, 1, 2, 1'b0, 1'b0);
        do_fetch(32'h0000_0100, 3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_fence_idle();
        @(negedge clk);
        pc_if = 30'(32'h0000_0200 >> 2); fetch_en = 1'b1; fence_i = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; fence_i = 1'b0;
        m_valid = '0;
        vectors++;
        if ({ic_req, ic_stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL fence_idle_lookup: req/stall got %b expected 00", {ic_req, ic_stall});
        end
        do_fetch(32'h0000_0100, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_spurious();
        @(negedge clk);
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0; ic_rdat_m_valid = 1'b1;
        m_valid = '0;
        @(negedge clk);
        ic_rdat_m_valid = 1'b0;
        vectors++;
        if ({ic_req, ic_stall, ic_ram_wadr_all} !== 14'h0) begin
            miscompares++;
            $display("FAIL spurious_idle: req=%b stall=%b wadr=%h expected 0/0/000", ic_req, ic_stall, ic_ram_wadr_all);
        end
        do_fetch(32'h0000_0100, 2, 1, 1'b1, 1'b0);
        do_fetch(32'h0000_0104, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_fence_wait();
        do_fetch(32'h0000_0300, 1, 3, 1'b0, 1'b1);
        do_fetch(32'h0000_0300, 1, 0, 1'b0, 1'b0);
        do_fetch(32'h0000_0308, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_delayed_ack();
`ifdef IC_PERF_CNT_EN
        logic [31:0] before;
        before = ic_miss_cnt;
`endif
        do_fetch(32'h1234_5670, 10, 2, 1'b0, 1'b0);
`ifdef IC_PERF_CNT_EN
        vectors++;
        if (ic_miss_cnt !== before + 32'd1) begin
            miscompares++;
            $display("FAIL miss_cnt: got %0d expected %0d", ic_miss_cnt, before + 32'd1);
        end
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        vectors++;
        if ({ic_hit_cnt, ic_miss_cnt} !== 64'h0) begin
            miscompares++;
            $display("FAIL perf_clr: hit=%0d miss=%0d expected 0/0", ic_hit_cnt, ic_miss_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_start();
        test_hit_after_fill();
        test_conflict();
        test_fence_idle();
        test_spurious();
        test_fence_wait();
        test_delayed_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ic_refill_ctrl.md
Name: ic_refill_ctrl

Overview:
- Instruction-cache miss/refill sequencer in front of the IF stage's inst_ram.
- Keeps a direct-mapped tag/valid array covering 128-bit (4-word) lines and checks the fetch PC against it every cycle.
- On a miss it stalls fetch, issues a line read to the DRAM bus and supplies the line write address to inst_ram.
- Generates the ic_stall, ic_stall_dly, ic_stall_fin and ic_stall_fin2 timing family consumed by the IF stage.

Parameters:
- IWIDTH, 14: word-address width of inst_ram. Line index = pc[IWIDTH+1:4] (IWIDTH-2 bits). Tag = pc[31:IWIDTH+2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc_if  in  30  [31:2] fetch PC of the current cycle
- fetch_en  in  1  lookup enable; low before pc_start and while the monitor owns the RAM
- fence_i  in  1  1-cycle pulse; invalidate all lines
- ic_req  out  1  DRAM line read request
- ic_req_adr  out  28  [31:4] line address of the request
- ic_req_ack  in  1  DRAM accepts the request
- ic_rdat_m_valid  in  1  refill data beat valid (one 128-bit beat per line)
- ic_ram_wadr_all  out  IWIDTH-2  line index written into inst_ram
- ic_stall  out  1  fetch stall
- ic_stall_dly  out  1  ic_stall delayed 1 cycle
- ic_stall_fin  out  1  1-cycle pulse, first cycle after ic_stall falls
- ic_stall_fin2  out  1  ic_stall_fin delayed 1 cycle

Behaviour:
- Lookup:
  - hit = valid[idx] & (tag[idx] == pc_if tag), read combinationally from flop arrays.
  - miss = fetch_en & ~hit in IDLE.
- State machine (IDLE, REQ, WAIT, FILL):
  - IDLE→REQ on miss. Latch the miss line address into madr. ic_stall=1 from the next cycle.
  - REQ: ic_req=1, ic_req_adr=madr. Hold until ic_req_ack, then →WAIT. Request and address stay stable while waiting for ack.
  - WAIT: on ic_rdat_m_valid, write tag[madr idx] and set valid[madr idx] (inst_ram writes the data in the same cycle). →FILL.
  - FILL: one bubble cycle for the RAM read-after-write; ic_stall still 1. →IDLE, ic_stall=0.
- Stall timing:
  - ic_stall is high in REQ, WAIT and FILL; the miss-to-resume minimum is 3 cycles plus DRAM latency.
  - ic_stall_dly, ic_stall_fin and ic_stall_fin2 are registered derivatives.
  - ic_stall_fin = ~ic_stall & ic_stall_dly.
- ic_ram_wadr_all = madr index whenever the state is not IDLE, 0 in IDLE. It is a registered value and is stable during WAIT.
- ic_rdat_m_valid outside WAIT is ignored: no tag update, no state change.
- Jump or pipe reset during a refill: this block has no cancel. The refill completes and the line is installed. The IF stage refetches after ic_stall falls; the new PC re-looks up and may miss again.
- fence_i:
  - In IDLE: clear all valid bits in 1 cycle. Lookup is suppressed that cycle (no miss is raised).
  - While busy: record it pending; clear after FILL, including the line just filled. The next lookup then misses.
- A miss is not raised while fetch_en=0. fetch_en falling mid-refill has no effect on the refill.
- Reset values:
  - state IDLE; all valid=0; tags=0; madr=0.
  - All outputs 0; ic_req_adr 0.

Optional Feature:
- IC_PERF_CNT_EN: adds outputs ic_hit_cnt[31:0] and ic_miss_cnt[31:0].
  - Hits count lookup cycles with fetch_en & hit in IDLE; misses count IDLE→REQ transitions.
  - Both counters wrap at 2^32, clear on rst_n and clear on the 1-cycle input perf_clr.
- Without the macro: no counters and no perf_clr port.

Decomposition:
- Shared package/header holds:
  - state encodings IC_IDLE=2'd0, IC_REQ=2'd1, IC_WAIT=2'd2, IC_FILL=2'd3;
  - line offset width 4 (bytes);
  - the NOP constant 32'h0000_0013 shared with the IF stage.
- One natural sub-module: ic_tag_array holding the tag/valid flops. It has a combinational read port, a single write port and a flash-clear input. The FSM stays in ic_refill_ctrl.

Test Plan:
- Cold start: reset, fetch_en=1, pc_if=0x100>>2 → ic_req=1 with ic_req_adr=0x10 the cycle after the miss. Ack after 2 cycles, valid 5 cycles later → ic_stall falls 1 cycle after FILL, ic_stall_fin is a single pulse, ic_stall_fin2 the next cycle.
- Hit after fill: same pc_if, then pc_if=0x10C>>2 → no ic_req, ic_stall stays 0.
- Conflict eviction: fill 0x0000_0100, then fetch 0x0001_0100 (same index 0x010, different tag) → miss and refill; ic_ram_wadr_all=0x010 during WAIT. Refetch of 0x100 misses again.
- Spurious valid: pulse ic_rdat_m_valid while in IDLE or REQ → no tag change, state unchanged.
- fence_i during WAIT: finish refill → line valid for 0 cycles after FILL; the next fetch of the same PC misses.
- Delayed ack: hold ic_req_ack=0 for 10 cycles → ic_req and ic_req_adr stable throughout; with IC_PERF_CNT_EN, ic_miss_cnt increments by exactly 1.
